// File: rtl/router_pkg.sv
// Shared definitions for the router packet sender: FSM encoding and header field widths.
package router_pkg;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2,
        ST_PAR  = 2'd3
    } state_t;
endpackage

// File: rtl/router_pkt_fifo.sv
// Payload byte FIFO with occupancy count; exposes the head and the entry behind it.
module router_pkt_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wr_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [7:0]               next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + PTR_W'(1);
    assign head      = mem[rd_ptr];
    assign next      = mem[rd_ptr_nx];

    // Storage is not reset; clearing the pointers is enough to discard contents.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nx;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/router_pkt_sender.sv
// Drives router_top with header, payload from the FIFO and an even parity byte, honouring busy.
module router_pkt_sender
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   send,
    input  logic [LEN_W-1:0]       send_len,
    input  logic [ADDR_W-1:0]      send_addr,
    input  logic                   busy,
    output logic                   pkt_valid,
    output logic [7:0]             data_out,
    output logic                   ready,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] wr_count,
    output logic                   wr_full
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t           state;
    logic [LEN_W-1:0] remain;
    logic [7:0]       parity;
    logic [7:0]       fifo_head;
    logic [7:0]       fifo_next;
    logic             fifo_empty;
    logic             pop;
    logic             send_bad;

    assign ready    = (state == ST_IDLE);
    assign pop      = (state == ST_PLD) && !busy && !fifo_empty;
    assign send_bad = (send_len == '0) || (send_addr == ADDR_ILLEGAL)
                      || (CNT_W'(send_len) > wr_count);

    router_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .head    (fifo_head),
        .next    (fifo_next),
        .count   (wr_count),
        .full    (wr_full),
        .empty   (fifo_empty)
    );

    // data_out always holds the byte currently offered; it advances only on accepted edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            parity    <= '0;
            remain    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send) begin
                        if (send_bad) begin
                            err <= 1'b1;
                        end else begin
                            remain    <= send_len;
                            pkt_valid <= 1'b1;
                            data_out  <= {send_len, send_addr};
                            state     <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (!busy) begin
                        parity   <= data_out;
                        data_out <= fifo_head;
                        state    <= ST_PLD;
                    end
                end
                ST_PLD: begin
                    if (!busy) begin
                        parity <= parity ^ data_out;
                        remain <= remain - LEN_W'(1);
                        if (remain == LEN_W'(1)) begin
                            pkt_valid <= 1'b0;
                            data_out  <= parity ^ data_out;
                            state     <= ST_PAR;
                        end else begin
                            data_out <= fifo_next;
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        done     <= 1'b1;
                        data_out <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_sender.sv
// Randomized and directed bench for router_pkt_sender against a queue-based packet model.
module tb_router_pkt_sender;
    localparam int DEPTH = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       send = 1'b0;
    logic [5:0] send_len = '0;
    logic [1:0] send_addr = '0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       ready;
    logic       done;
    logic       err;
    logic [6:0] wr_count;
    logic       wr_full;

    router_pkt_sender #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .send      (send),
        .send_len  (send_len),
        .send_addr (send_addr),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .wr_count  (wr_count),
        .wr_full   (wr_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       pl;
    } item_t;

    logic [7:0] fifo_q [$];
    item_t      exp_q  [$];
    logic       exp_done = 1'b0;
    logic       exp_err  = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [7:0] ed;
        ev = 1'b0;
        ed = 8'h00;
        if (exp_q.size() != 0) begin
            ev = exp_q[0].v;
            ed = exp_q[0].d;
        end
        check_val("pkt_valid", 32'(pkt_valid), 32'(ev));
        check_val("data_out", 32'(data_out), 32'(ed));
        check_val("ready", 32'(ready), 32'(exp_q.size() == 0));
        check_val("done", 32'(done), 32'(exp_done));
        check_val("err", 32'(err), 32'(exp_err));
        check_val("wr_count", 32'(wr_count), 32'(fifo_q.size()));
        check_val("wr_full", 32'(wr_full), 32'(fifo_q.size() == DEPTH));
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input logic w, input logic [7:0] wd, input logic s,
                        input logic [5:0] l, input logic [1:0] a, input logic b);
        int    pre_size;
        bit    idle;
        item_t it;
        logic [7:0] par;
        wr_en = w; wr_data = wd; send = s; send_len = l; send_addr = a; busy = b;
        @(posedge clock);
        pre_size = fifo_q.size();
        idle     = (exp_q.size() == 0);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (!idle && !b) begin
            it = exp_q.pop_front();
            if (it.pl) void'(fifo_q.pop_front());
            if (!it.v) exp_done = 1'b1;
        end
        if (w && pre_size < DEPTH) fifo_q.push_back(wd);
        if (idle && s) begin
            if (l == 0 || a == 2'd3 || int'(l) > pre_size) begin
                exp_err = 1'b1;
            end else begin
                par = {l, a};
                exp_q.push_back('{v: 1'b1, d: {l, a}, pl: 1'b0});
                for (int i = 0; i < int'(l); i++) begin
                    exp_q.push_back('{v: 1'b1, d: fifo_q[i], pl: 1'b1});
                    par = par ^ fifo_q[i];
                end
                exp_q.push_back('{v: 1'b0, d: par, pl: 1'b0});
            end
        end
        @(negedge clock);
        wr_en = 1'b0; send = 1'b0;
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, 8'h00, 1'b0, 6'd0, 2'd0, 1'b0);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            idle_step();
            n++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle_step();
    endtask

    initial begin
        #3;
        check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_val("rst_data_out", 32'(data_out), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_wr_count", 32'(wr_count), 32'd0);
        check_val("rst_done_err", 32'({done, err}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle_step();

        // Basic packet
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd5, 2'd2, 1'b0);
        check_val("basic_hdr", 32'(data_out), 32'h16);
        for (int i = 0; i < 6; i++) idle_step();
        check_val("basic_par", 32'(data_out), 32'h07);
        check_val("basic_par_valid", 32'(pkt_valid), 32'd0);
        idle_step();
        check_val("basic_done", 32'(done), 32'd1);
        check_val("basic_count", 32'(wr_count), 32'd0);

        // Stall while 0x12 is offered
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd5, 2'd2, 1'b0);
        idle_step();
        idle_step();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 6'd0, 2'd0, 1'b1);
            check_val("stall_hold", 32'(data_out), 32'h12);
        end
        drain(20);

        // Rejects
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd2, 2'd3, 1'b0);
        check_val("rej_addr3", 32'({err, pkt_valid}), 32'b10);
        step(1'b0, 8'h00, 1'b1, 6'd6, 2'd1, 1'b0);
        check_val("rej_len6", 32'({err, pkt_valid}), 32'b10);
        step(1'b0, 8'h00, 1'b1, 6'd0, 2'd0, 1'b0);
        check_val("rej_len0", 32'({err, pkt_valid}), 32'b10);
        check_val("rej_count", 32'(wr_count), 32'd5);
        step(1'b0, 8'h00, 1'b1, 6'd5, 2'd0, 1'b0);
        drain(20);

        // FIFO boundary
        for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 6'd0, 2'd0, 1'b0);
        check_val("full_count", 32'(wr_count), 32'd64);
        check_val("full_flag", 32'(wr_full), 32'd1);
        step(1'b1, 8'hEE, 1'b0, 6'd0, 2'd0, 1'b0);
        check_val("full_drop", 32'(wr_count), 32'd64);
        step(1'b0, 8'h00, 1'b1, 6'd63, 2'd1, 1'b0);
        drain(80);
        check_val("len63_count", 32'(wr_count), 32'd1);
        step(1'b1, 8'($urandom), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd2, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 6'd0, 2'd0, 1'b0);
        drain(20);
        check_val("push_during_send", 32'(wr_count), 32'd4);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            logic [5:0] l;
            l = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 10));
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 5) == 0),
                 l, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        drain(200);

        // Async reset in the middle of the payload
        while (fifo_q.size() < 10) step(1'b1, 8'($urandom), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd8, 2'd1, 1'b0);
        idle_step();
        idle_step();
        check_val("mid_pld_valid", 32'(pkt_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("arst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_val("arst_data_out", 32'(data_out), 32'd0);
        check_val("arst_ready", 32'(ready), 32'd1);
        check_val("arst_wr_count", 32'(wr_count), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 6'd0, 2'd0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 6'd3, 2'd0, 1'b0);
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
